// File: rtl/clock_div_pkg.sv
// clock_div_pkg: phase encoding, reset divisor and divisor arithmetic shared by the divider.
package clock_div_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} phase_t;
  localparam int DIV_DEFAULT = 2;
  // 32-bit arithmetic keeps D = 2^SIZE-1 free of overflow for any practical SIZE
  function automatic int unsigned div_eff(input int unsigned n);
    return n == 0 ? 1 : n;
  endfunction
  function automatic int unsigned div_hi(input int unsigned d);
    return (d + 1) >> 1;
  endfunction
  function automatic int unsigned div_lo(input int unsigned d);
    return d >> 1;
  endfunction
endpackage

// File: rtl/clock_div_multi_if.sv
// clock_div_multi_if: valid/ready divisor write port (wdata, sel, valid, ready).
interface clock_div_multi_if #(
  parameter int SIZE = 8,
  parameter int CHANNELS = 4
);
  localparam int SW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic [SIZE-1:0] wdata;
  logic [SW-1:0] sel;
  logic valid;
  logic ready;
  modport master(output wdata, sel, valid, input ready);
  modport slave(input wdata, sel, valid, output ready);
endinterface

// File: rtl/clock_div_chan.sv
// clock_div_chan: one divider channel; divisor updates land on period boundaries.
// CLK_DIV_ODD50_EN adds a negedge stage giving odd divisors an exact 50% duty.
module clock_div_chan import clock_div_pkg::*; #(
  parameter int SIZE = 8,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            wr,
  input  logic [SIZE-1:0] wdata,
  output logic            clk_out,
  output logic            tick,
  output logic            pend_v
);
  phase_t phase, phase_nx;
  logic [SIZE-1:0] cur, cur_nx, pend, cnt, cnt_nx;
  logic out_r, d1, gate_n, bnd;
  int unsigned d_cur, d_nx;
  always_comb begin
    d_cur = div_eff(32'(cur));
    bnd = 1'b0;
    phase_nx = phase;
    cnt_nx = cnt - 1'b1;
    case (phase)
      HIGH: if (cnt == '0) begin
        bnd = div_lo(d_cur) == 0;
        phase_nx = LOW;
        cnt_nx = SIZE'(div_lo(d_cur) - 1);
      end
      LOW: bnd = cnt == '0;
      default: bnd = 1'b1;
    endcase
    cur_nx = bnd && pend_v ? pend : cur;
    d_nx = div_eff(32'(cur_nx));
    if (bnd) begin
      phase_nx = enable ? HIGH : IDLE;
      cnt_nx = enable ? SIZE'(div_hi(d_nx) - 1) : '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase <= IDLE;
      cur <= SIZE'(DEFAULT_DIV);
      pend <= '0;
      pend_v <= 1'b0;
      cnt <= '0;
      out_r <= 1'b0;
      d1 <= 1'b0;
      tick <= 1'b0;
    end else begin
      phase <= phase_nx;
      cur <= cur_nx;
      cnt <= cnt_nx;
      pend_v <= wr || (pend_v && !bnd);
      if (wr) pend <= wdata;
      out_r <= phase_nx == HIGH;
      d1 <= phase_nx == HIGH && d_nx == 1;
      tick <= bnd && enable;
    end
  // gate_n only moves while clk is low, so the D=1 pass-through never chops a pulse
`ifdef CLK_DIV_ODD50_EN
  logic out_n, odd;
  always_ff @(posedge clk or posedge reset)
    if (reset) odd <= 1'b0;
    else odd <= d_nx[0] && d_nx >= 3;
  always_ff @(negedge clk or posedge reset)
    if (reset) begin
      gate_n <= 1'b0;
      out_n <= 1'b0;
    end else begin
      gate_n <= d1;
      out_n <= out_r;
    end
  assign clk_out = (clk && gate_n) || (out_r && !d1 && (out_n || !odd));
`else
  always_ff @(negedge clk or posedge reset)
    if (reset) gate_n <= 1'b0;
    else gate_n <= d1;
  assign clk_out = (clk && gate_n) || (out_r && !d1);
`endif
endmodule

// File: rtl/clock_div_multi.sv
// clock_div_multi: CHANNELS independent integer dividers of clk with a shared divisor write port.
// Odd-divisor 50% duty is selected per build by CLK_DIV_ODD50_EN inside clock_div_chan.
module clock_div_multi import clock_div_pkg::*; #(
  parameter int SIZE = 8,
  parameter int CHANNELS = 4,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  clock_div_multi_if.slave    div,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] div_pending
);
  assign div.ready = int'(div.sel) >= CHANNELS || !div_pending[div.sel];
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clock_div_chan #(.SIZE(SIZE), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk(clk),
      .reset(reset),
      .enable(enable[i]),
      .wr(div.valid && div.ready && int'(div.sel) == i),
      .wdata(div.wdata),
      .clk_out(clk_out[i]),
      .tick(tick[i]),
      .pend_v(div_pending[i])
    );
  end
endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi: directed + randomized stimulus checked against a period-position reference model.
module tb_clock_div_multi;
  localparam int SIZE = 8, CH = 4;
`ifdef CLK_DIV_ODD50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [CH-1:0] enable = '0, clk_out, tick, div_pending;
  logic [2:0] enable3 = '0, clk_out3, tick3, pending3;
  clock_div_multi_if #(.SIZE(SIZE), .CHANNELS(CH)) bus ();
  clock_div_multi_if #(.SIZE(SIZE), .CHANNELS(3)) bus3 ();
  clock_div_multi #(.SIZE(SIZE), .CHANNELS(CH), .DEFAULT_DIV(2)) dut (
    .clk(clk), .reset(reset), .div(bus), .enable(enable),
    .clk_out(clk_out), .tick(tick), .div_pending(div_pending));
  clock_div_multi #(.SIZE(SIZE), .CHANNELS(3), .DEFAULT_DIV(2)) dut3 (
    .clk(clk), .reset(reset), .div(bus3), .enable(enable3),
    .clk_out(clk_out3), .tick(tick3), .div_pending(pending3));
  always #5 clk = ~clk;

  int cur_m[CH], pend_m[CH], d_m[CH], pos_m[CH];
  bit pv_m[CH], run_m[CH], tick_m[CH], pd1_m[CH];
  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int n);
    return n == 0 ? 1 : n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      cur_m[c] = 2; pend_m[c] = 0; d_m[c] = 2; pos_m[c] = 0;
      pv_m[c] = 0; run_m[c] = 0; tick_m[c] = 0; pd1_m[c] = 0;
    end
  endtask

  // A channel's period is D cycles indexed by pos; it is high for the first ceil(D/2) positions.
  task automatic model_edge();
    bit acc;
    acc = bus.valid && (int'(bus.sel) >= CH || !pv_m[bus.sel]);
    for (int c = 0; c < CH; c++) begin
      pd1_m[c] = run_m[c] && d_m[c] == 1;
      if (!run_m[c] || pos_m[c] == d_m[c] - 1) begin
        if (pv_m[c]) begin
          cur_m[c] = pend_m[c];
          pv_m[c] = 0;
        end
        d_m[c] = eff(cur_m[c]);
        run_m[c] = enable[c];
        pos_m[c] = 0;
        tick_m[c] = enable[c];
      end else begin
        pos_m[c]++;
        tick_m[c] = 0;
      end
      if (acc && int'(bus.sel) == c) begin
        pend_m[c] = int'(bus.wdata);
        pv_m[c] = 1;
      end
    end
  endtask

  // D=1 pulses trail the state by one cycle (the gate opens at the following negedge).
  task automatic step();
    logic [CH-1:0] hi, lo, tk, pv;
    @(posedge clk);
    model_edge();
    for (int c = 0; c < CH; c++) begin
      lo[c] = run_m[c] && d_m[c] > 1 && pos_m[c] < (d_m[c] + 1) / 2;
      hi[c] = pd1_m[c] || (lo[c] && !(ODD50 && d_m[c] % 2 == 1 && pos_m[c] == 0));
      tk[c] = tick_m[c];
      pv[c] = pv_m[c];
    end
    #1;
    check("clk_out_high_half", clk_out, hi);
    check("tick", tick, tk);
    check("div_pending", div_pending, pv);
    check("div_ready", bus.ready, !pv_m[bus.sel]);
    @(negedge clk);
    #1;
    check("clk_out_low_half", clk_out, lo);
  endtask

  task automatic write(input int sel, input int data);
    int n;
    n = 0;
    while (pv_m[sel] && n < 1000) begin
      step();
      n++;
    end
    check("write_wait_expired", n >= 1000, 0);
    bus.valid = 1'b1;
    bus.sel = 2'(sel);
    bus.wdata = 8'(data);
    step();
    bus.valid = 1'b0;
  endtask

  initial begin
    int n;
    bus.valid = 1'b0; bus.sel = '0; bus.wdata = '0;
    bus3.valid = 1'b0; bus3.sel = '0; bus3.wdata = '0;
    model_reset();
    #12;
    check("reset_clk_out", clk_out, 0);
    check("reset_tick", tick, 0);
    check("reset_pending", div_pending, 0);
    check("reset_ready", bus.ready, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    enable = 4'b0001;
    repeat (8) step();
    enable = 4'b1111;
    write(1, 5);
    repeat (16) step();
    write(2, 0);
    repeat (6) step();
    write(2, 1);
    repeat (6) step();
    write(2, 4);
    repeat (10) step();
    write(3, 6);
    n = 0;
    while (!(d_m[3] == 6 && pos_m[3] == 0 && !pv_m[3]) && n < 100) begin step(); n++; end
    check("ch3_start_expired", n >= 100, 0);
    enable[3] = 1'b0;
    repeat (14) step();
    enable[3] = 1'b1;
    write(0, 3);
    n = 0;
    while (!(d_m[0] == 3 && pos_m[0] == 2 && !pv_m[0]) && n < 100) begin step(); n++; end
    check("ch0_boundary_expired", n >= 100, 0);
    write(0, 8);
    repeat (24) step();
    bus3.valid = 1'b1;
    bus3.sel = 2'd3;
    bus3.wdata = 8'd5;
    #1;
    check("oor_ready", bus3.ready, 1);
    step();
    check("oor_pending", pending3, 0);
    bus3.valid = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 15) == 0) enable[$urandom_range(0, CH - 1)] ^= 1'b1;
      bus.valid = $urandom_range(0, 3) == 0;
      bus.sel = 2'($urandom_range(0, CH - 1));
      bus.wdata = 8'($urandom_range(0, 9) == 0 ? $urandom_range(0, 40) : $urandom_range(0, 9));
      step();
    end
    bus.valid = 1'b0;
    enable = '1;
    write(1, 255);
    n = 0;
    while (!(d_m[1] == 255 && pos_m[1] == 10) && n < 800) begin step(); n++; end
    check("d255_start_expired", n >= 800, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clk_out", clk_out, 0);
    check("async_reset_tick", tick, 0);
    check("async_reset_pending", div_pending, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (20) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
